// File: rtl/i2c_slave_regfile.sv
// Register bank behind the I2C slave: edge-detected write/read strobes, single-byte
// writes, multi-byte big-endian read word, sticky access-error flag and traffic counters.
module i2c_slave_regfile #(
  parameter logic [6:0]          SLAVE_ADDR   = 7'b010_0011,
  parameter int unsigned         NUM_REGS     = 16,
  parameter int unsigned         TX_DATA_BYTE = 1,
  parameter logic [NUM_REGS-1:0] WR_MASK      = {NUM_REGS{1'b1}},
  parameter logic [7:0]          INIT_VAL     = 8'h00
) (
  input  logic                        SYSTEM_CLK,
  input  logic                        RESETn,
  input  logic                        iwrite_en,
  input  logic                        iread_en,
  input  logic [6:0]                  rx_address,
  input  logic [7:0]                  rx_offset,
  input  logic [7:0]                  rx_data,
  output logic [TX_DATA_BYTE*8-1:0]   tx_data,
  output logic [NUM_REGS*8-1:0]       regs_flat,
  output logic                        err_sticky,
  input  logic                        err_clr,
  output logic [7:0]                  wr_count,
  output logic [7:0]                  rd_count
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned TX_W  = TX_DATA_BYTE * 8;

  logic [7:0]      r_regs [NUM_REGS];
  logic            r_wr_d;
  logic            r_rd_d;
  logic [TX_W-1:0] r_tx_data;
  logic            r_err;
  logic [7:0]      r_wr_cnt;
  logic [7:0]      r_rd_cnt;

  logic             w_wr_pulse;
  logic             w_rd_pulse;
  logic             w_addr_hit;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic             w_wr_ok;
  logic             w_wr_err;
  logic             w_rd_acc;
  logic             w_rd_err;
  logic [TX_W-1:0]  w_rd_word;

  assign w_wr_pulse = iwrite_en & ~r_wr_d;
  assign w_rd_pulse = iread_en & ~r_rd_d;
  assign w_addr_hit = (rx_address == SLAVE_ADDR);
  assign w_in_range = (32'(rx_offset) < NUM_REGS);
  assign w_idx      = IDX_W'(rx_offset);

  assign w_wr_ok  = w_wr_pulse & w_addr_hit & w_in_range & WR_MASK[w_idx];
  assign w_wr_err = w_wr_pulse & w_addr_hit & ~(w_in_range & WR_MASK[w_idx]);
  assign w_rd_acc = w_rd_pulse & w_addr_hit;
  assign w_rd_err = w_rd_acc & ~w_in_range;

  // Read word: byte 0 in the MSB position, indices wrap around the bank.
  always_comb begin
    w_rd_word = '1;
    if (w_in_range) begin
      for (int unsigned k = 0; k < TX_DATA_BYTE; k++) begin
        w_rd_word[(TX_DATA_BYTE-k)*8-1 -: 8] =
          r_regs[IDX_W'((32'(rx_offset) + k) % NUM_REGS)];
      end
    end
  end

  always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_wr_d    <= 1'b0;
      r_rd_d    <= 1'b0;
      r_tx_data <= '0;
      r_err     <= 1'b0;
      r_wr_cnt  <= 8'd0;
      r_rd_cnt  <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= INIT_VAL;
    end else begin
      r_wr_d <= iwrite_en;
      r_rd_d <= iread_en;
      if (w_wr_ok) begin
        r_regs[w_idx] <= rx_data;
        r_wr_cnt      <= 8'(r_wr_cnt + 8'd1);
      end
      if (w_rd_acc) begin
        r_tx_data <= w_rd_word;
        r_rd_cnt  <= 8'(r_rd_cnt + 8'd1);
      end
      // An error event in the same cycle as err_clr keeps the flag set.
      if (w_wr_err | w_rd_err) r_err <= 1'b1;
      else if (err_clr)        r_err <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = r_regs[g];
  end

  assign tx_data    = r_tx_data;
  assign err_sticky = r_err;
  assign wr_count   = r_wr_cnt;
  assign rd_count   = r_rd_cnt;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench for i2c_slave_regfile: vector table with scoreboard queue plus
// hand-written sequences for counter wrap and reset asserted mid-strobe.
module tb_i2c_slave_regfile;

  localparam int unsigned NR   = 16;
  localparam int unsigned TXB  = 2;
  localparam logic [6:0]  ADDR = 7'b010_0011;
  localparam logic [15:0] WRM  = 16'hFFDF;

  logic              SYSTEM_CLK = 1'b0;
  logic              RESETn     = 1'b0;
  logic              iwrite_en  = 1'b0;
  logic              iread_en   = 1'b0;
  logic [6:0]        rx_address = '0;
  logic [7:0]        rx_offset  = '0;
  logic [7:0]        rx_data    = '0;
  logic              err_clr    = 1'b0;
  logic [TXB*8-1:0]  tx_data;
  logic [NR*8-1:0]   regs_flat;
  logic              err_sticky;
  logic [7:0]        wr_count;
  logic [7:0]        rd_count;

  i2c_slave_regfile #(
    .SLAVE_ADDR(ADDR), .NUM_REGS(NR), .TX_DATA_BYTE(TXB), .WR_MASK(WRM), .INIT_VAL(8'h00)
  ) dut (
    .SYSTEM_CLK(SYSTEM_CLK), .RESETn(RESETn), .iwrite_en(iwrite_en), .iread_en(iread_en),
    .rx_address(rx_address), .rx_offset(rx_offset), .rx_data(rx_data), .tx_data(tx_data),
    .regs_flat(regs_flat), .err_sticky(err_sticky), .err_clr(err_clr),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 SYSTEM_CLK = ~SYSTEM_CLK;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [6:0]  addr;
    logic [7:0]  off;
    logic [7:0]  data;
    bit          clr;
    int          hold;
    logic [15:0] exp_tx;
    bit          exp_err;
    logic [7:0]  exp_wc;
    logic [7:0]  exp_rc;
  } vec_t;

  vec_t       vecs[$];
  vec_t       sb[$];
  logic [7:0] mdl [NR];
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic vec_t mk(bit wr, bit rd, logic [6:0] a, logic [7:0] off, logic [7:0] d,
                              bit clr, int hold, logic [15:0] tx, bit e,
                              logic [7:0] wc, logic [7:0] rc);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.off = off; v.data = d; v.clr = clr; v.hold = hold;
    v.exp_tx = tx; v.exp_err = e; v.exp_wc = wc; v.exp_rc = rc;
    return v;
  endfunction

  function automatic logic [NR*8-1:0] mdl_flat();
    logic [NR*8-1:0] f;
    for (int i = 0; i < NR; i++) f[8*i +: 8] = mdl[i];
    return f;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    int   o;
    @(negedge SYSTEM_CLK);
    iwrite_en = v.wr; iread_en = v.rd; rx_address = v.addr;
    rx_offset = v.off; rx_data = v.data; err_clr = v.clr;
    sb.push_back(v);
    o = int'(v.off);
    if (v.wr && v.addr == ADDR && o < NR) begin
      if (WRM[o[3:0]]) mdl[o[3:0]] = v.data;
    end
    @(posedge SYSTEM_CLK);
    @(negedge SYSTEM_CLK);
    // Offset/data change while the strobe is held must not matter.
    err_clr = 1'b0; rx_offset = v.off ^ 8'h5A; rx_data = ~v.data;
    e = sb.pop_front();
    chk($sformatf("v%0d_tx", idx),   128'(tx_data),    128'(e.exp_tx));
    chk($sformatf("v%0d_err", idx),  128'(err_sticky), 128'(e.exp_err));
    chk($sformatf("v%0d_wc", idx),   128'(wr_count),   128'(e.exp_wc));
    chk($sformatf("v%0d_rc", idx),   128'(rd_count),   128'(e.exp_rc));
    chk($sformatf("v%0d_regs", idx), 128'(regs_flat),  128'(mdl_flat()));
    repeat (v.hold - 1) @(negedge SYSTEM_CLK);
    iwrite_en = 1'b0; iread_en = 1'b0;
    @(negedge SYSTEM_CLK);
    chk($sformatf("v%0d_wc_held", idx), 128'(wr_count), 128'(e.exp_wc));
    chk($sformatf("v%0d_rc_held", idx), 128'(rd_count), 128'(e.exp_rc));
  endtask

  initial begin
    for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
    //              wr rd addr   off    data   clr hold tx        err wc     rc
    vecs.push_back(mk(1, 1, 7'h22, 8'd3,  8'h77, 0, 4,  16'h0000, 0, 8'd0, 8'd0));
    vecs.push_back(mk(1, 0, ADDR,  8'd3,  8'hA5, 0, 20, 16'h0000, 0, 8'd1, 8'd0));
    vecs.push_back(mk(0, 1, ADDR,  8'd3,  8'h00, 0, 5,  16'hA500, 0, 8'd1, 8'd1));
    vecs.push_back(mk(1, 0, ADDR,  8'd14, 8'h11, 0, 3,  16'hA500, 0, 8'd2, 8'd1));
    vecs.push_back(mk(1, 0, ADDR,  8'd15, 8'h22, 0, 3,  16'hA500, 0, 8'd3, 8'd1));
    vecs.push_back(mk(1, 0, ADDR,  8'd0,  8'h33, 0, 3,  16'hA500, 0, 8'd4, 8'd1));
    vecs.push_back(mk(0, 1, ADDR,  8'd15, 8'h00, 0, 6,  16'h2233, 0, 8'd4, 8'd2));
    vecs.push_back(mk(0, 1, ADDR,  8'd14, 8'h00, 0, 6,  16'h1122, 0, 8'd4, 8'd3));
    vecs.push_back(mk(1, 0, ADDR,  8'd16, 8'h99, 0, 3,  16'h1122, 1, 8'd4, 8'd3));
    vecs.push_back(mk(0, 1, ADDR,  8'd20, 8'h00, 0, 3,  16'hFFFF, 1, 8'd4, 8'd4));
    vecs.push_back(mk(0, 0, ADDR,  8'd0,  8'h00, 1, 1,  16'hFFFF, 0, 8'd4, 8'd4));
    vecs.push_back(mk(1, 0, ADDR,  8'd5,  8'h7E, 0, 3,  16'hFFFF, 1, 8'd4, 8'd4));
    vecs.push_back(mk(1, 0, ADDR,  8'd5,  8'h7E, 1, 3,  16'hFFFF, 1, 8'd4, 8'd4));
    vecs.push_back(mk(0, 0, ADDR,  8'd0,  8'h00, 1, 1,  16'hFFFF, 0, 8'd4, 8'd4));
    vecs.push_back(mk(1, 1, ADDR,  8'd2,  8'h55, 0, 8,  16'h00A5, 0, 8'd5, 8'd5));
    vecs.push_back(mk(0, 1, ADDR,  8'd1,  8'h00, 0, 3,  16'h0055, 0, 8'd5, 8'd6));
    vecs.push_back(mk(1, 0, ADDR,  8'd255,8'h01, 0, 3,  16'h0055, 1, 8'd5, 8'd6));

    repeat (3) @(negedge SYSTEM_CLK);
    chk("rst_tx",   128'(tx_data),    128'(16'h0000));
    chk("rst_regs", 128'(regs_flat),  128'(mdl_flat()));
    chk("rst_err",  128'(err_sticky), 128'(1'b0));
    chk("rst_wc",   128'(wr_count),   128'(8'd0));
    chk("rst_rc",   128'(rd_count),   128'(8'd0));
    RESETn = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // 251 short writes take wr_count from 5 through 255 and wrap to 0.
    for (int i = 0; i < 251; i++) begin
      @(negedge SYSTEM_CLK);
      iwrite_en = 1'b1; rx_address = ADDR; rx_offset = 8'd7; rx_data = 8'(i);
      @(negedge SYSTEM_CLK);
      iwrite_en = 1'b0;
    end
    mdl[7] = 8'd250;
    @(negedge SYSTEM_CLK);
    chk("wrap_wc",   128'(wr_count),  128'(8'd0));
    chk("wrap_regs", 128'(regs_flat), 128'(mdl_flat()));

    // Reset mid-strobe, then release with the strobe still high.
    @(negedge SYSTEM_CLK);
    iwrite_en = 1'b1; rx_address = ADDR; rx_offset = 8'd4; rx_data = 8'h66;
    @(posedge SYSTEM_CLK);
    #2;
    RESETn = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
    chk("mid_rst_tx",   128'(tx_data),    128'(16'h0000));
    chk("mid_rst_regs", 128'(regs_flat),  128'(mdl_flat()));
    chk("mid_rst_err",  128'(err_sticky), 128'(1'b0));
    chk("mid_rst_wc",   128'(wr_count),   128'(8'd0));
    chk("mid_rst_rc",   128'(rd_count),   128'(8'd0));
    @(negedge SYSTEM_CLK);
    RESETn = 1'b1;
    mdl[4] = 8'h66;
    @(posedge SYSTEM_CLK);
    @(negedge SYSTEM_CLK);
    chk("post_rst_wc",   128'(wr_count),  128'(8'd1));
    chk("post_rst_regs", 128'(regs_flat), 128'(mdl_flat()));
    repeat (3) @(negedge SYSTEM_CLK);
    iwrite_en = 1'b0;
    @(negedge SYSTEM_CLK);
    chk("post_rst_wc_held", 128'(wr_count), 128'(8'd1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
